// File: rtl/cpu_divmod_unit.sv
// Multi-cycle signed/unsigned integer divider producing quotient and remainder.
// Non-restoring radix-2 core; fixed latency of WIDTH+2 edges after the start edge.
module cpu_divmod_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             unsgn_or_sgn,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] denom,
  input  logic             abort,
  output logic             can_accept_cmd,
  output logic             data_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP,
    DONE
  } state_t;

  state_t state, state_next;

  // Captured command
  logic             sgn_r;
  logic [WIDTH-1:0] num_r;
  logic [WIDTH-1:0] denom_r;

  // Iteration datapath
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qacc;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;

  // Combinational helpers
  logic             num_neg;
  logic             den_neg;
  logic             denom_zero;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step_res;
  logic [WIDTH:0]   rem_fix;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic [WIDTH-1:0] zero_quot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = start ? PREP : IDLE;
      DONE:    state_next = start ? PREP : IDLE;
      PREP: begin
        if (abort)           state_next = IDLE;
        else if (denom_zero) state_next = DONE;
        else                 state_next = ITER;
      end
      ITER: begin
        if (abort)                state_next = IDLE;
        else if (cnt == CW'(1))   state_next = FIXUP;
        else                      state_next = ITER;
      end
      FIXUP:   state_next = abort ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    num_neg    = sgn_r & num_r[WIDTH-1];
    den_neg    = sgn_r & denom_r[WIDTH-1];
    denom_zero = (denom_r == '0);
    mag_n      = num_neg ? ('0 - num_r) : num_r;
    mag_d      = den_neg ? ('0 - denom_r) : denom_r;
    // The W+1-bit remainder may wrap on the shift; the add/sub result always
    // lies in [-d, d), so modular arithmetic keeps it exact.
    shifted    = {prem[WIDTH-1:0], qacc[WIDTH-1]};
    step_res   = prem[WIDTH] ? (shifted + {1'b0, dvsr}) : (shifted - {1'b0, dvsr});
    rem_fix    = prem[WIDTH] ? (prem + {1'b0, dvsr}) : prem;
    q_final    = neg_q ? ('0 - qacc) : qacc;
    r_final    = neg_r ? ('0 - rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];
    zero_quot  = num_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r       <= 1'b0;
      num_r       <= '0;
      denom_r     <= '0;
      dvsr        <= '0;
      prem        <= '0;
      qacc        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sgn_r   <= unsgn_or_sgn;
            num_r   <= num;
            denom_r <= denom;
          end
        end
        PREP: begin
          if (!abort) begin
            qacc  <= mag_n;
            dvsr  <= mag_d;
            prem  <= '0;
            neg_q <= num_neg ^ den_neg;
            neg_r <= num_neg;
            cnt   <= CW'(WIDTH);
            if (denom_zero) begin
              quot        <= zero_quot;
              rem         <= num_r;
              div_by_zero <= 1'b1;
            end
          end
        end
        ITER: begin
          if (!abort) begin
            prem <= step_res;
            qacc <= {qacc[WIDTH-2:0], ~step_res[WIDTH]};
            cnt  <= cnt - CW'(1);
          end
        end
        FIXUP: begin
          if (!abort) begin
            quot        <= q_final;
            rem         <= r_final;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign can_accept_cmd = (state == IDLE) || (state == DONE);
  assign data_ready     = (state == DONE);

endmodule

// File: tb/tb_cpu_divmod_unit.sv
// Directed self-checking bench for cpu_divmod_unit at WIDTH=32 and WIDTH=64.
module tb_cpu_divmod_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sgn, abort;
  logic [31:0] num, denom, quot, rem;
  logic        dbz, ready, can_acc;

  logic        start64, sgn64, abort64;
  logic [63:0] num64, denom64, quot64, rem64;
  logic        dbz64, ready64, can_acc64;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cpu_divmod_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .unsgn_or_sgn(sgn),
    .num(num), .denom(denom), .abort(abort),
    .can_accept_cmd(can_acc), .data_ready(ready),
    .quot(quot), .rem(rem), .div_by_zero(dbz)
  );

  cpu_divmod_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .unsgn_or_sgn(sgn64),
    .num(num64), .denom(denom64), .abort(abort64),
    .can_accept_cmd(can_acc64), .data_ready(ready64),
    .quot(quot64), .rem(rem64), .div_by_zero(dbz64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; the next edge is the sampling edge (edge 0).
  task automatic op32(input logic s, input logic [31:0] n, input logic [31:0] d, output int lat);
    start = 1'b1; sgn = s; num = n; denom = d;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    num = $urandom; denom = $urandom; sgn = ~s;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (ready) begin lat = e; break; end
    end
  endtask

  task automatic op64(input logic s, input logic [63:0] n, input logic [63:0] d, output int lat);
    start64 = 1'b1; sgn64 = s; num64 = n; denom64 = d;
    @(posedge clk); #1;
    start64 = 1'b0;
    num64 = {$urandom, $urandom}; denom64 = {$urandom, $urandom}; sgn64 = ~s;
    lat = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (ready64) begin lat = e; break; end
    end
  endtask

  task automatic expect32(input string tag, input logic s, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez, input int elat);
    int lat;
    op32(s, n, d, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_dbz"}, dbz, ez);
  endtask

  task automatic expect64(input string tag, input logic s, input logic [63:0] n, input logic [63:0] d,
                          input logic [63:0] eq, input logic [63:0] er, input int elat);
    int lat;
    op64(s, n, d, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_quot"}, quot64, eq);
    check({tag, "_rem"}, rem64, er);
    check({tag, "_dbz"}, dbz64, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    start = 0; sgn = 0; num = 0; denom = 0; abort = 0;
    start64 = 0; sgn64 = 0; num64 = 0; denom64 = 0; abort64 = 0;
    rst_n = 1'b0;
    #2;
    check("rst_quot", quot, 32'h0);
    check("rst_rem", rem, 32'h0);
    check("rst_dbz", dbz, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_can_acc", can_acc, 1'b1);
    check("rst_can_acc64", can_acc64, 1'b1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    expect32("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34);
    @(posedge clk); #1;
    check("ready_one_cycle", ready, 1'b0);
    check("idle_can_acc", can_acc, 1'b1);

    expect32("s_m100_7", 1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34);
    expect32("s_100_m7", 1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 34);
    expect32("u5_0",     1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1);
    expect32("s_m5_0",   1'b1, 32'hFFFFFFFB,  32'd0,         32'd1,         32'hFFFFFFFB,  1'b1, 1);
    expect32("s7_0",     1'b1, 32'd7,         32'd0,         32'hFFFFFFFF,  32'd7,         1'b1, 1);
    expect32("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34);
    expect32("s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34);
    expect32("u_max_max",1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 34);
    expect32("u_max_16", 1'b0, 32'hFFFFFFFF,  32'd16,        32'h0FFFFFFF,  32'hF,         1'b0, 34);
    expect32("u3_10",    1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0, 34);

    // start together with abort during DONE: accepted, no idle gap
    abort = 1'b1;
    expect32("b2b_9_4",  1'b0, 32'd9,         32'd4,         32'd2,         32'd1,         1'b0, 34);
    @(posedge clk); #1;

    // abort mid-ITER leaves the held results untouched
    start = 1'b1; sgn = 1'b0; num = 32'd100; denom = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_can_acc", can_acc, 1'b1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("abort_no_ready", seen, 1'b0);
    check("abort_quot", quot, 32'd2);
    check("abort_rem", rem, 32'd1);
    check("abort_dbz", dbz, 1'b0);

    // start while busy is dropped, not queued
    start = 1'b1; sgn = 1'b0; num = 32'd3; denom = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      if (e == 5) begin start = 1'b1; num = 32'd50; denom = 32'd5; end
      @(posedge clk); #1;
      start = 1'b0;
      if (ready) begin lat = e; break; end
    end
    check("busy_lat", lat, 34);
    check("busy_quot", quot, 32'd0);
    check("busy_rem", rem, 32'd3);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("busy_not_queued", seen, 1'b0);

    // asynchronous reset mid-ITER
    start = 1'b1; sgn = 1'b0; num = 32'd100; denom = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_quot", quot, 32'h0);
    check("arst_rem", rem, 32'h0);
    check("arst_ready", ready, 1'b0);
    check("arst_can_acc", can_acc, 1'b1);
    #1 rst_n = 1'b1;
    expect32("post_rst_7_7", 1'b0, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 34);
    @(posedge clk); #1;

    expect64("u64_2p63_3", 1'b0, 64'h8000000000000000, 64'd3,
             64'h2AAAAAAAAAAAAAAA, 64'd2, 66);
    expect64("s64_m9_2",   1'b1, 64'hFFFFFFFFFFFFFFF7, 64'd2,
             64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 66);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
